// File: rtl/reset_ce_seq_pkg.sv
// rtl/reset_ce_seq_pkg.sv - shared types and sizing helpers for reset_ce_sequencer
package reset_ce_seq_pkg;

    typedef enum logic [1:0] {
        HOLD  = 2'd0,
        STAGE = 2'd1,
        RUN   = 2'd2
    } seq_state_t;

    // Bits needed to hold values 0..value-1 (minimum 1).
    function automatic int clog2_f(input int value);
        int w;
        w = 0;
        while ((1 << w) < value) begin
            w++;
        end
        if (w < 1) begin
            w = 1;
        end
        return w;
    endfunction

    function automatic int max_f(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ce_cycle_counter.sv
// rtl/ce_cycle_counter.sv - CE-qualified up counter with terminal-count strobe and sync clear
//
// Ports:
//   i_clk, i_rst      clock, asynchronous active-high reset
//   i_ce              global clock enable; counting only advances when high
//   i_en              phase enable; counter frozen when low
//   i_clr             synchronous clear, dominates counting and suppresses o_tc
//   i_terminal        value at which the counter wraps back to zero
//   o_tc              high on the edge where the count equals i_terminal and advances
module ce_cycle_counter #(
    parameter int WIDTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_ce,
    input  logic             i_en,
    input  logic             i_clr,
    input  logic [WIDTH-1:0] i_terminal,
    output logic             o_tc
);

    logic [WIDTH-1:0] r_count;

    assign o_tc = i_ce & i_en & ~i_clr & (r_count == i_terminal);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_ce && i_en) begin
            if (o_tc) begin
                r_count <= '0;
            end else begin
                r_count <= r_count + WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/reset_ce_sequencer.sv
// rtl/reset_ce_sequencer.sv - reset hold followed by staged CE release and READY
//
// Optional feature macro: RESET_CE_SEQ_COUNT_EN (adds RESET_COUNT output).
//
// Ports:
//   CLK          system clock
//   RESET        asynchronous active-high reset
//   CE           global clock enable qualifying all counting
//   RST_REQ      synchronous software reset request
//   RST_OUT      registered reset to downstream blocks
//   CE_OUT       per-stage clock enables, CE gated by registered stage enables
//   READY        registered, high once every stage is enabled
//   RESET_COUNT  (optional) saturating count of completed sequences
module reset_ce_sequencer
    import reset_ce_seq_pkg::*;
#(
    parameter int NUM_STAGES   = 4,
    parameter int RESET_CYCLES = 8,
    parameter int STAGE_GAP    = 4
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  CE,
    input  logic                  RST_REQ,
    output logic                  RST_OUT,
    output logic [NUM_STAGES-1:0] CE_OUT,
    output logic                  READY
`ifdef RESET_CE_SEQ_COUNT_EN
    ,
    output logic [7:0]            RESET_COUNT
`endif
);

    localparam int CNT_W = clog2_f(max_f(RESET_CYCLES, STAGE_GAP) + 1);
    localparam int IDX_W = clog2_f(NUM_STAGES + 1);

    seq_state_t            r_state;
    seq_state_t            w_state_nxt;
    logic                  r_rst_out;
    logic                  w_rst_out_nxt;
    logic [NUM_STAGES-1:0] r_stage_en;
    logic [NUM_STAGES-1:0] w_stage_en_nxt;
    logic                  r_ready;
    logic                  w_ready_nxt;
    logic [IDX_W-1:0]      r_idx;
    logic [IDX_W-1:0]      w_idx_nxt;

    logic                  w_cnt_en;
    logic [CNT_W-1:0]      w_terminal;
    logic                  w_tc;

    // One counter serves both timed phases; only the terminal value changes.
    assign w_cnt_en   = (r_state != RUN);
    assign w_terminal = (r_state == HOLD) ? CNT_W'(RESET_CYCLES - 1)
                                          : CNT_W'(STAGE_GAP - 1);

    // RST_REQ clears the counter and masks the strobe, so a coincident
    // request can never also release a stage or leave HOLD.
    ce_cycle_counter #(
        .WIDTH (CNT_W)
    ) u_cnt (
        .i_clk      (CLK),
        .i_rst      (RESET),
        .i_ce       (CE),
        .i_en       (w_cnt_en),
        .i_clr      (RST_REQ),
        .i_terminal (w_terminal),
        .o_tc       (w_tc)
    );

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state    <= HOLD;
            r_rst_out  <= 1'b1;
            r_stage_en <= '0;
            r_ready    <= 1'b0;
            r_idx      <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_rst_out  <= w_rst_out_nxt;
            r_stage_en <= w_stage_en_nxt;
            r_ready    <= w_ready_nxt;
            r_idx      <= w_idx_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_rst_out_nxt  = r_rst_out;
        w_stage_en_nxt = r_stage_en;
        w_ready_nxt    = r_ready;
        w_idx_nxt      = r_idx;

        if (RST_REQ) begin
            w_state_nxt    = HOLD;
            w_rst_out_nxt  = 1'b1;
            w_stage_en_nxt = '0;
            w_ready_nxt    = 1'b0;
            w_idx_nxt      = '0;
        end else begin
            case (r_state)
                HOLD: begin
                    w_rst_out_nxt = 1'b1;
                    if (w_tc) begin
                        w_rst_out_nxt = 1'b0;
                        w_state_nxt   = STAGE;
                    end
                end
                STAGE: begin
                    if (w_tc) begin
                        for (int k = 0; k < NUM_STAGES; k++) begin
                            if (r_idx == IDX_W'(k)) begin
                                w_stage_en_nxt[k] = 1'b1;
                            end
                        end
                        w_idx_nxt = r_idx + IDX_W'(1);
                        if (r_idx == IDX_W'(NUM_STAGES - 1)) begin
                            w_ready_nxt = 1'b1;
                            w_state_nxt = RUN;
                        end
                    end
                end
                RUN: begin
                    w_state_nxt = RUN;
                end
                default: begin
                    w_state_nxt = HOLD;
                end
            endcase
        end
    end

    assign RST_OUT = r_rst_out;
    assign CE_OUT  = {NUM_STAGES{CE}} & r_stage_en;
    assign READY   = r_ready;

`ifdef RESET_CE_SEQ_COUNT_EN
    logic [7:0] r_reset_count;

    // Survives RST_REQ on purpose: it counts sequences across soft resets.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_reset_count <= '0;
        end else if (w_ready_nxt && !r_ready && (r_reset_count != 8'hFF)) begin
            r_reset_count <= r_reset_count + 8'd1;
        end
    end

    assign RESET_COUNT = r_reset_count;
`endif

endmodule

// File: doc/reset_ce_sequencer.md
Name: reset_ce_sequencer

Overview:
- Generates the reset and staged clock-enable sequence that ce_delay_after_reset-style consumers receive.
- On power-up reset or a synchronous software request, it holds a reset output for a fixed number of CE-qualified cycles.
- It then releases per-stage CE outputs one at a time, a fixed gap apart, and finally asserts READY.
- Sits between the board-level reset/CE source and the sensor pipeline stages.

Parameters:
- NUM_STAGES, 4, number of staged CE outputs (1..16).
- RESET_CYCLES, 8, CE-qualified cycles RST_OUT stays high after reset release (>=1).
- STAGE_GAP, 4, CE-qualified cycles between successive stage enables, and before stage 0 (>=1).

Ports:
- CLK  input  1  system clock.
- RESET  input  1  asynchronous, active-high reset.
- CE  input  1  global clock enable; all counting is qualified by CE=1.
- RST_REQ  input  1  synchronous software reset request, sampled on posedge CLK.
- RST_OUT  output  1  registered reset to downstream blocks, active-high.
- CE_OUT  output  NUM_STAGES  per-stage clock enables; CE_OUT[k] = CE & stage_en[k] (combinational AND with registered stage_en).
- READY  output  1  registered; high once all stages are enabled.

Behaviour:
- Async RESET=1: immediately RST_OUT=1, stage_en=0 (so CE_OUT=0), READY=0, cnt=0, idx=0, state=HOLD. Held for the whole RESET assertion.
- FSM states: HOLD, STAGE, RUN. All transitions occur on posedge CLK.
- Counter widths: cnt is $clog2(max(RESET_CYCLES,STAGE_GAP)+1) bits; idx is $clog2(NUM_STAGES+1) bits. No wrap occurs in legal operation.
- HOLD:
  - RST_OUT=1.
  - On each edge with CE=1, cnt increments.
  - On the edge where CE=1 and cnt==RESET_CYCLES-1: RST_OUT<=0, cnt<=0, state<=STAGE.
- STAGE:
  - On each edge with CE=1, cnt increments.
  - On the edge where CE=1 and cnt==STAGE_GAP-1: stage_en[idx]<=1, idx<=idx+1, cnt<=0.
  - If idx==NUM_STAGES-1 at that edge: READY<=1, state<=RUN.
- RUN: outputs are static; stage_en stays all ones; counters are frozen.
- CE=0: counters hold value and no transitions occur. If CE never rises, RST_OUT stays high indefinitely, by design.
- RST_REQ=1 at an edge:
  - Highest synchronous priority, valid in any state.
  - RST_OUT<=1, stage_en<=0, READY<=0, cnt<=0, idx<=0, state<=HOLD.
  - A held RST_REQ keeps cnt at 0; counting starts on the first edge after RST_REQ falls.
- RST_REQ coincident with a stage-release or HOLD-exit edge: RST_REQ wins, and no stage is enabled on that edge.
- Async RESET overrides RST_REQ.
- Total latency from reset release to READY, with CE=1 continuously: RESET_CYCLES + NUM_STAGES*STAGE_GAP edges.

Optional Feature:
- Macro: RESET_CE_SEQ_COUNT_EN.
- Defined:
  - Adds output port RESET_COUNT [7:0].
  - Saturating count of completed sequences: increments on the edge READY rises, saturates at 255.
  - Cleared only by async RESET; RST_REQ does not clear it.
- Undefined: the port and its logic are absent, and the rest of the behaviour is identical.

Decomposition:
- Package reset_ce_seq_pkg holds:
  - the typedef enum logic [1:0] {HOLD, STAGE, RUN} for the state;
  - a function for counter width (clog2 helper).
- Optional sub-module ce_cycle_counter: CE-qualified counter with terminal-count strobe and synchronous clear, reused for both the HOLD and STAGE phases. Otherwise the block is flat.

Test Plan:
All scenarios use default parameters.
- Power-up, CE=1 continuously, RESET pulsed then released:
  - RST_OUT falls after edge 8;
  - CE_OUT[0] rises after edge 12, CE_OUT[1] after 16, CE_OUT[2] after 20, CE_OUT[3] and READY after 24.
- CE toggling 1,0,1,0 after reset release: every milestone of the previous scenario doubles (RST_OUT falls at edge 16, READY at 48).
- RST_REQ=1 for one cycle at edge 18, so stage0 and stage1 are on:
  - next cycle RST_OUT=1, CE_OUT=0000, READY=0;
  - READY returns 24 edges after RST_REQ falls.
- RST_REQ asserted on exactly edge 12 (stage0 release edge): CE_OUT[0] stays 0 and RST_OUT=1 afterwards.
- Async RESET asserted mid-STAGE between clock edges: outputs go to reset values before the next edge; the sequence restarts from HOLD after release.
- With RESET_CE_SEQ_COUNT_EN defined:
  - after 3 completed sequences (two via RST_REQ), RESET_COUNT=3;
  - async RESET clears it to 0.
